rxd_frame_shift: RTL and testbench
==================================

Name: rxd_frame_shift

Overview:
- Parametrised receive shifter for the IrDA RX path; successor to the fixed 10-bit right-shift register.
- Samples serial_in on each rshift strobe from the baud/sample logic and tracks frame position with a bit counter and FSM.
- Handles start bit, DATA_BITS data bits LSB-first, optional parity, and 1 or 2 stop bits.
- Presents the received word with a one-cycle valid pulse and error flags to the RX controller.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- rshift  input  1  bit-sample strobe; one clk wide; one strobe per bit period.
- serial_in  input  1  demodulated RX bit; valid when rshift=1.
- data  output  DATA_BITS  last complete received word.
- frame_valid  output  1  one-cycle pulse when data and the flags update.
- parity_err  output  1  parity mismatch on the last frame; 0 when PARITY_MODE=0.
- framing_err  output  1  a stop-bit sample was 0 on the last frame.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (clk 0 => 1 with reset=1):
  - state=IDLE, shift register=0, bit count=0.
  - data=0, frame_valid=0, parity_err=0, framing_err=0, busy=0.
  - Reset has priority over rshift in the same cycle.
- All state advances only on cycles with rshift=1. With rshift=0, everything holds, except frame_valid, which clears.
- IDLE:
  - rshift with serial_in=0 => DATA; bit count=0; parity accumulator = 0 for even, 1 for odd.
  - rshift with serial_in=1 => stay in IDLE (line idle or glitch).
- DATA:
  - Each rshift shifts right: MSB = serial_in. Bits are LSB-first, so after DATA_BITS shifts bit 0 holds the first data bit.
  - Parity accumulator ^= serial_in; bit count increments.
  - On the DATA_BITS-th sample => PARITY if PARITY_MODE!=0, else STOP.
- PARITY:
  - One rshift: accumulator ^= serial_in; pending parity error = accumulator != 0 after XOR.
  - => STOP; stop count=0.
- STOP:
  - Each rshift: if serial_in=0, set pending framing error.
  - After STOP_BITS samples => IDLE.
  - In that same clk edge: data <= shift register; parity_err and framing_err <= pending values; frame_valid=1 for exactly one cycle.
- Latency: frame_valid is asserted in the cycle after the final stop-bit rshift edge. That is one register stage; outputs are registered.
- A frame with a framing error is still delivered (data updated, framing_err=1). The RX controller decides whether to discard it.
- data, parity_err and framing_err hold until the next frame completes or reset.
- Reset mid-frame: partial frame discarded, no frame_valid, returns to IDLE.
- Back-to-back frames: a start bit sampled on the rshift immediately after the last stop bit is accepted normally; no idle gap is required.
- The shift register is DATA_BITS wide; no bits beyond DATA_BITS are stored.

Optional Feature:
- Macro: RXD_FRAME_INV_EN.
- Defined: serial_in is inverted at the input, before any sampling logic, for IrDA front ends with an active-high pulse output. Start bit = 1 on the pin; stop bits = 0 on the pin.
- Undefined: serial_in is used as-is.
- No other behaviour changes.

Test Plan:
- Defaults, feed start 0, data 0xA5 LSB-first (1,0,1,0,0,1,0,1), stop 1 => one frame_valid pulse, data=0xA5, parity_err=0, framing_err=0, busy low afterward.
- PARITY_MODE=1, data 0x07 with parity bit 0 (odd count of ones) => data=0x07, parity_err=1. Repeat with parity bit 1 => parity_err=0.
- STOP_BITS=2, data 0x3C, second stop sample 0 => framing_err=1, data=0x3C, frame_valid pulses once.
- Assert reset after the 4th data bit of a frame => no frame_valid, busy=0, data=0. Next full frame 0x5A is received correctly.
- rshift with serial_in=1 held for 20 strobes in IDLE => busy stays 0, no frame_valid. Then two back-to-back frames 0x01 and 0xFE => two pulses with data matching in order.
- DATA_BITS=5 with RXD_FRAME_INV_EN defined, pin sequence 1, inverted 0x13, 0 => data=0x13, no errors.

Source files
------------

// File: rtl/rxd_frame_shift.sv
// Parametrised IrDA RX frame shifter: start, LSB-first data, parity, stop.
// Define RXD_FRAME_INV_EN to invert serial_in for active-high front ends.
module rxd_frame_shift #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rshift,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic ACC_INIT = (PARITY_MODE == 2);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_BITS-1:0] sh, sh_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 acc, acc_n;
  logic                 pep, pep_n;
  logic                 fep, fep_n;
  logic                 done;
  logic                 rx_bit;

`ifdef RXD_FRAME_INV_EN
  assign rx_bit = ~serial_in;
`else
  assign rx_bit = serial_in;
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and datapath next values; everything holds without rshift.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    acc_n   = acc;
    pep_n   = pep;
    fep_n   = fep;
    done    = 1'b0;
    if (rshift) begin
      unique case (state)
        IDLE: begin
          if (!rx_bit) begin
            state_n = DATA;
            cnt_n   = '0;
            acc_n   = ACC_INIT;
            pep_n   = 1'b0;
            fep_n   = 1'b0;
          end
        end
        DATA: begin
          sh_n  = {rx_bit, sh[DATA_BITS-1:1]};
          acc_n = acc ^ rx_bit;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST_DATA) begin
            state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            cnt_n   = '0;
          end
        end
        PARITY: begin
          acc_n   = acc ^ rx_bit;
          pep_n   = acc ^ rx_bit;
          state_n = STOP;
          cnt_n   = '0;
        end
        STOP: begin
          if (!rx_bit) fep_n = 1'b1;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST_STOP) begin
            state_n = IDLE;
            cnt_n   = '0;
            done    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Frame-tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh  <= '0;
      cnt <= '0;
      acc <= 1'b0;
      pep <= 1'b0;
      fep <= 1'b0;
    end else begin
      sh  <= sh_n;
      cnt <= cnt_n;
      acc <= acc_n;
      pep <= pep_n;
      fep <= fep_n;
    end
  end

  // Registered frame delivery with one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      data        <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      frame_valid <= done;
      if (done) begin
        data        <= sh;
        parity_err  <= pep;
        framing_err <= fep_n;
      end
    end
  end

endmodule

// File: tb/tb_rxd_frame_shift.sv
// Scoreboard bench for rxd_frame_shift across four parameter sets.
// Instances: 0 default, 1 even parity, 2 two stops, 3 five data bits.
module tb_rxd_frame_shift;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  localparam logic INV =
`ifdef RXD_FRAME_INV_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rs[4];
  logic si[4];

  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic fv[4], pe[4], fe[4], bz[4];
  logic [8:0] dv[4];

  exp_t sb[4][$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  rxd_frame_shift u0 (
    .clk(clk), .reset(reset), .rshift(rs[0]), .serial_in(si[0]),
    .data(d0), .frame_valid(fv[0]), .parity_err(pe[0]),
    .framing_err(fe[0]), .busy(bz[0])
  );
  rxd_frame_shift #(.PARITY_MODE(1)) u1 (
    .clk(clk), .reset(reset), .rshift(rs[1]), .serial_in(si[1]),
    .data(d1), .frame_valid(fv[1]), .parity_err(pe[1]),
    .framing_err(fe[1]), .busy(bz[1])
  );
  rxd_frame_shift #(.STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rshift(rs[2]), .serial_in(si[2]),
    .data(d2), .frame_valid(fv[2]), .parity_err(pe[2]),
    .framing_err(fe[2]), .busy(bz[2])
  );
  rxd_frame_shift #(.DATA_BITS(5)) u3 (
    .clk(clk), .reset(reset), .rshift(rs[3]), .serial_in(si[3]),
    .data(d3), .frame_valid(fv[3]), .parity_err(pe[3]),
    .framing_err(fe[3]), .busy(bz[3])
  );

  assign dv[0] = {1'b0, d0};
  assign dv[1] = {1'b0, d1};
  assign dv[2] = {1'b0, d2};
  assign dv[3] = {4'b0, d3};

  // Scoreboard: every frame_valid pops and compares one expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fv[k] === 1'b1) begin
        exp_t e;
        total++;
        if (sb[k].size() == 0) begin
          $display("FAIL unexpected_frame inst%0d got data=%h", k, dv[k]);
        end else begin
          e = sb[k].pop_front();
          if (dv[k] !== e.d || pe[k] !== e.pe || fe[k] !== e.fe)
            $display("FAIL frame inst%0d got d=%h pe=%b fe=%b want d=%h pe=%b fe=%b",
                     k, dv[k], pe[k], fe[k], e.d, e.pe, e.fe);
          else passed++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic send_bit(input int k, input logic b);
    @(negedge clk);
    rs[k] = 1'b1;
    si[k] = b ^ INV;
    @(negedge clk);
    rs[k] = 1'b0;
  endtask

  task automatic send_vec(input int k, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(k, v[i]);
  endtask

  task automatic push(input int k, input logic [8:0] d,
                      input logic p, input logic f);
    exp_t e;
    e.d = d;
    e.pe = p;
    e.fe = f;
    sb[k].push_back(e);
  endtask

  task automatic drain(input int k, input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb[k].size() == 0) break;
      @(negedge clk);
    end
    total++;
    if (sb[k].size() != 0)
      $display("FAIL %s pending=%0d want 0", name, sb[k].size());
    else passed++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      rs[k] = 1'b0;
      si[k] = 1'b1 ^ INV;
    end
    reset = 1'b1;
    @(negedge clk);
    rs[0] = 1'b1;
    si[0] = 1'b0 ^ INV;
    @(negedge clk);
    rs[0] = 1'b0;
    si[0] = 1'b1 ^ INV;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dv[k] !== 9'd0 || fv[k] !== 1'b0 || pe[k] !== 1'b0 ||
          fe[k] !== 1'b0 || bz[k] !== 1'b0)
        $display("FAIL reset_state inst%0d d=%h fv=%b pe=%b fe=%b busy=%b want all 0",
                 k, dv[k], fv[k], pe[k], fe[k], bz[k]);
      else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bz[0] !== 1'b0) $display("FAIL reset_priority busy=%b want 0", bz[0]);
    else passed++;
  endtask

  task automatic test_basic();
    send_bit(0, 1'b0);
    total++;
    if (bz[0] !== 1'b1) $display("FAIL busy_after_start busy=%b want 1", bz[0]);
    else passed++;
    push(0, 9'h0A5, 1'b0, 1'b0);
    send_vec(0, {30'b1, 8'hA5}, 9);
    drain(0, "basic_drain");
    total++;
    if (bz[0] !== 1'b0) $display("FAIL busy_after_frame busy=%b want 0", bz[0]);
    else passed++;
    push(0, 9'h033, 1'b0, 1'b1);
    send_vec(0, {1'b0, 8'h33, 1'b0}, 10);
    drain(0, "single_stop_ferr_drain");
    repeat (5) @(negedge clk);
    total++;
    if (d0 !== 8'h33 || fe[0] !== 1'b1)
      $display("FAIL hold d=%h fe=%b want 33 1", d0, fe[0]);
    else passed++;
  endtask

  task automatic test_parity();
    push(1, 9'h007, 1'b1, 1'b0);
    send_vec(1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    drain(1, "parity_bad_drain");
    push(1, 9'h007, 1'b0, 1'b0);
    send_vec(1, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    drain(1, "parity_good_drain");
    push(1, 9'h0C3, 1'b0, 1'b0);
    send_vec(1, {1'b1, 1'b0, 8'hC3, 1'b0}, 11);
    drain(1, "parity_c3_drain");
  endtask

  task automatic test_stop2();
    push(2, 9'h03C, 1'b0, 1'b1);
    send_vec(2, {1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    drain(2, "stop2_ferr_drain");
    push(2, 9'h081, 1'b0, 1'b0);
    send_vec(2, {1'b1, 1'b1, 8'h81, 1'b0}, 11);
    drain(2, "stop2_ok_drain");
  endtask

  task automatic test_reset_mid();
    send_vec(0, {8'h5A, 1'b0}, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bz[0] !== 1'b0 || d0 !== 8'h00)
      $display("FAIL reset_mid busy=%b d=%h want 0 00", bz[0], d0);
    else passed++;
    push(0, 9'h05A, 1'b0, 1'b0);
    send_vec(0, {1'b1, 8'h5A, 1'b0}, 10);
    drain(0, "after_reset_drain");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      send_bit(0, 1'b1);
      total++;
      if (bz[0] !== 1'b0) $display("FAIL idle_busy step%0d busy=%b want 0", i, bz[0]);
      else passed++;
    end
    push(0, 9'h001, 1'b0, 1'b0);
    push(0, 9'h0FE, 1'b0, 1'b0);
    send_vec(0, {1'b1, 8'hFE, 1'b0, 1'b1, 8'h01, 1'b0}, 20);
    drain(0, "b2b_drain");
  endtask

  task automatic test_inv5();
    push(3, 9'h013, 1'b0, 1'b0);
    send_vec(3, {1'b1, 5'h13, 1'b0}, 7);
    drain(3, "five_bit_drain");
    push(3, 9'h00A, 1'b0, 1'b1);
    send_vec(3, {1'b0, 5'h0A, 1'b0}, 7);
    drain(3, "five_bit_ferr_drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_reset_mid();
    test_back_to_back();
    test_inv5();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
